mips_cpu_bus_sequencer: RTL and testbench

MIPS_CPU_BUS_SEQUENCER -- requirements
Module: mips_cpu_bus_sequencer

---
 rtl/mips_cpu_bus_sequencer.sv | 138 +++++++++++++
 tb/tb_mips_cpu_bus_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mips_cpu_bus_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_cpu_bus_sequencer                                                     |
// | Multi-cycle CPU control sequencer: fetch/decode/execute with bus waits.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mips_cpu_bus_sequencer #(
  parameter int N_EXEC    = 2,
  parameter int MEM_STAGE = 1,
  parameter int TIMEOUT   = 0,
  parameter int CW        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              waitrequest,
  input  logic              load,
  input  logic              store,
  input  logic              halt,
  output logic              fetch,
  output logic              decode,
  output logic [N_EXEC-1:0] exec,
  output logic              halted,
  output logic              bus_error,
  output logic              instr_retired,
  output logic [CW-1:0]     cycle_count,
  output logic [CW-1:0]     instr_count
);

  localparam int SW = (N_EXEC > 1) ? $clog2(N_EXEC) : 1;
  localparam logic [SW-1:0] c_mem_idx    = SW'(MEM_STAGE - 1);
  localparam logic [SW-1:0] c_last_idx   = SW'(N_EXEC - 1);
  localparam logic [7:0]    c_wait_limit = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_stage;
  logic [SW-1:0] w_stage_nxt;
  logic [7:0]    r_wait;
  logic          r_bus_error;
  logic [CW-1:0] r_cycle_count;
  logic [CW-1:0] r_instr_count;
  logic          w_mem_access;
  logic          w_bus_wait;
  logic          w_timeout;

  // The execute stages share one state code; the stage index selects the one-hot bit.
  always_comb begin
    w_state_nxt  = r_state;
    w_stage_nxt  = r_stage;
    w_mem_access = (r_state == S_EXEC) && (r_stage == c_mem_idx) && (load | store);
    w_bus_wait   = waitrequest && ((r_state == S_FETCH) || w_mem_access);
    w_timeout    = (TIMEOUT != 0) && w_bus_wait && (r_wait == c_wait_limit);

    case (r_state)
      S_FETCH: begin
        if (!waitrequest) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_EXEC;
        w_stage_nxt = '0;
      end
      S_EXEC: begin
        if (!w_bus_wait) begin
          if (r_stage == c_last_idx) begin
            w_state_nxt = halt ? S_HALTED : S_FETCH;
            w_stage_nxt = '0;
          end else begin
            w_stage_nxt = r_stage + SW'(1);
          end
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt = S_FETCH;
        w_stage_nxt = '0;
      end
    endcase

    if (w_timeout) begin
      w_state_nxt = S_HALTED;
      w_stage_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_stage       <= '0;
      r_wait        <= 8'd0;
      r_bus_error   <= 1'b0;
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else if (active) begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_wait  <= (w_bus_wait && !w_timeout) ? r_wait + 8'd1 : 8'd0;
      if (w_timeout) begin
        r_bus_error <= 1'b1;
      end
      if (r_state != S_HALTED) begin
        r_cycle_count <= r_cycle_count + CW'(1);
      end
      if (instr_retired) begin
        r_instr_count <= r_instr_count + CW'(1);
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < N_EXEC; k++) begin : g_exec
      assign exec[k] = (r_state == S_EXEC) && (r_stage == SW'(k));
    end
  endgenerate

  assign fetch         = (r_state == S_FETCH);
  assign decode        = (r_state == S_DECODE);
  assign halted        = (r_state == S_HALTED);
  assign bus_error     = r_bus_error;
  assign instr_retired = exec[N_EXEC-1] & active & ~reset;
  assign cycle_count   = r_cycle_count;
  assign instr_count   = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips_cpu_bus_sequencer                                                  |
// | Directed bench with expected-state scoreboard for the CPU sequencer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mips_cpu_bus_sequencer;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam logic [1:0] F = 2'd0, D = 2'd1, E = 2'd2, H = 2'd3;

  logic          clk = 1'b0;
  logic          reset = 1'b1, active = 1'b0, waitrequest = 1'b0;
  logic          load = 1'b0, store = 1'b0, halt = 1'b0;
  logic          fetch, decode, halted, bus_error, instr_retired;
  logic [N-1:0]  exec;
  logic [CW-1:0] cycle_count, instr_count;

  mips_cpu_bus_sequencer #(
    .N_EXEC(N), .MEM_STAGE(2), .TIMEOUT(4), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .active(active), .waitrequest(waitrequest),
    .load(load), .store(store), .halt(halt),
    .fetch(fetch), .decode(decode), .exec(exec), .halted(halted),
    .bus_error(bus_error), .instr_retired(instr_retired),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    code;
    logic [N-1:0]  ex;
    logic          berr;
    logic          ret;
    logic [CW-1:0] cyc;
    logic [CW-1:0] ins;
  } exp_t;

  exp_t          q[$];
  exp_t          m;
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] ecyc = '0;
  logic [CW-1:0] eins = '0;
  logic [1:0]    acode;
  int            onehot;

  // Applies inputs for one edge and queues the hand-computed state after it.
  task automatic step(input logic r, a, wr, ld, st, h,
                      input logic [1:0] code, input logic [N-1:0] ex,
                      input logic be, input int dc, input int di);
    exp_t e;
    reset = r; active = a; waitrequest = wr; load = ld; store = st; halt = h;
    if (r) begin
      ecyc = '0;
      eins = '0;
    end else begin
      ecyc = ecyc + CW'(dc);
      eins = eins + CW'(di);
    end
    e.code = code; e.ex = ex; e.berr = be; e.ret = ex[N-1] & a & ~r;
    e.cyc = ecyc; e.ins = eins;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // One instruction: fs fetch stalls, ms stalls in EXEC2; wr/halt noise in non-sampling states.
  task automatic run_instr(input int fs, input logic ld, st, input int ms, input logic h);
    for (int i = 0; i < fs; i++) step(0, 1, 1, 0, 0, 0, F, 4'b0000, 0, 1, 0);
    step(0, 1, 0, ld, st, 1, D, 4'b0000, 0, 1, 0);
    step(0, 1, 1, ld, st, 1, E, 4'b0001, 0, 1, 0);
    step(0, 1, 1, ld, st, 1, E, 4'b0010, 0, 1, 0);
    for (int i = 0; i < ms; i++) step(0, 1, 1, ld, st, 0, E, 4'b0010, 0, 1, 0);
    step(0, 1, 0, ld, st, 0, E, 4'b0100, 0, 1, 0);
    step(0, 1, 1, 1, 1, 0, E, 4'b1000, 0, 1, 0);
    step(0, 1, 1, 0, 0, h, h ? H : F, 4'b0000, 0, 1, 1);
  endtask

  always begin
    @(posedge clk);
    #2;
    if (q.size() > 0) begin
      m = q.pop_front();
      tests++;
      acode  = fetch ? F : decode ? D : (exec != '0) ? E : H;
      onehot = $countones({fetch, decode, exec, halted});
      if (onehot != 1 || acode != m.code || exec != m.ex || bus_error != m.berr ||
          instr_retired != m.ret || cycle_count != m.cyc || instr_count != m.ins) begin
        fails++;
        $display("FAIL step %0d: got code=%0d exec=%b berr=%b ret=%b cyc=%0d ins=%0d hot=%0d, want code=%0d exec=%b berr=%b ret=%b cyc=%0d ins=%0d hot=1",
                 tests, acode, exec, bus_error, instr_retired, cycle_count, instr_count, onehot,
                 m.code, m.ex, m.berr, m.ret, m.cyc, m.ins);
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset regardless of active
    step(1, 0, 1, 1, 1, 1, F, 4'b0000, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, F, 4'b0000, 0, 0, 0);
    // Plain, load with 3-cycle bus wait, store with fetch/mem waits at the limit
    run_instr(0, 0, 0, 0, 0);
    run_instr(2, 1, 0, 3, 0);
    run_instr(3, 0, 1, 3, 0);
    // Clock enable low for 5 cycles in EXEC1
    step(0, 1, 0, 0, 0, 0, D, 4'b0000, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, E, 4'b0001, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 1, E, 4'b0001, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, E, 4'b0010, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, E, 4'b0100, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, E, 4'b1000, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, F, 4'b0000, 0, 1, 1);
    // Halt instruction, then HALTED is sticky and counters freeze
    run_instr(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, H, 4'b0000, 0, 0, 0);
    step(0, 1, 1, 1, 0, 1, H, 4'b0000, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, F, 4'b0000, 0, 0, 0);
    // Fetch timeout after 4 stalled edges
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, F, 4'b0000, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0, H, 4'b0000, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, H, 4'b0000, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, F, 4'b0000, 0, 0, 0);
    // Store timeout in EXEC2
    step(0, 1, 0, 0, 1, 0, D, 4'b0000, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, E, 4'b0001, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, E, 4'b0010, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0, E, 4'b0010, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0, H, 4'b0000, 1, 1, 0);
    step(1, 1, 1, 0, 1, 0, F, 4'b0000, 0, 0, 0);
    // Reset mid-wait abandons the transfer
    step(0, 1, 0, 1, 0, 0, D, 4'b0000, 0, 1, 0);
    step(0, 1, 0, 1, 0, 0, E, 4'b0001, 0, 1, 0);
    step(0, 1, 0, 1, 0, 0, E, 4'b0010, 0, 1, 0);
    step(0, 1, 1, 1, 0, 0, E, 4'b0010, 0, 1, 0);
    step(1, 1, 1, 1, 0, 0, F, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
